// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
// Subtract feeds ~B into the cell and seeds the carry with 1 (A + ~B + 1).
module bAdd (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (x_i & c_i) | (y_i & c_i);
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d;
  logic             op_q, op_d, carry_q, carry_d;
  logic             cb_q, cb_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, c_out, last_bit;

  bAdd u_cell (
    .x_i (a_q[0]),
    .y_i (b_q[0] ^ op_q),
    .c_i (carry_q),
    .s_o (sum_bit),
    .c_o (c_out)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cb_d    = cb_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;
          sh_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {sum_bit, sh_q[WIDTH-1:1]};
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        // The visible result only changes once all bits are in; the MSB's
        // carry-in is still in carry_q here, which gives the signed overflow.
        if (last_bit) begin
          res_d   = {sum_bit, sh_q[WIDTH-1:1]};
          cb_d    = c_out ^ op_q;
          ovf_d   = carry_q ^ c_out;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign cb     = cb_q;
  assign ovf    = ovf_q;
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial adder/subtractor, LSB first, one bit per clock, using a single bAdd full-adder cell plus shift registers and a small FSM.
- Subtract is A + ~B + 1: B is inverted into the cell and the carry is seeded with 1.
- Trades latency for area against the ripple adder, for datapaths where an ALU op may take multiple cycles (e.g. a microcoded ALU path).
- Start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add A+B, 1 = subtract A-B; captured with operands
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  sum or difference; held until next accepted start
- cb  output  1  carry-out for add; borrow for subtract (borrow = ~final carry)
- ovf  output  1  signed two's-complement overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset: all of the following are 0 at the first edge with rst=1, regardless of state:
  - state = IDLE; busy, done, result, cb and ovf all 0;
  - shift registers and bit counter cleared.
- rst dominates start.
- A reset mid-operation aborts the operation: no done pulse, and result reads 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → capture a, b, op.
  - Carry register ← op (1 for subtract).
  - Counter ← 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - Bit i = counter feeds bAdd with A[i], B[i]^op and the carry register.
  - Sum bit shifts into the result register from the MSB side; carry register ← c_out.
  - Counter increments.
  - At bit WIDTH-1, also latch carry-in of that bit (for ovf) and c_out.
  - After the WIDTH-th RUN edge, go to DONE.
- DONE:
  - done=1, result/cb/ovf valid.
  - Next edge returns to IDLE unconditionally.
  - start is ignored in DONE.
- Latency:
  - start accepted at edge E0; RUN edges are E1..EWIDTH.
  - done is high for exactly the cycle after EWIDTH and low after EWIDTH+1.
  - busy is high from after E0 through EWIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or done: ignored, with no effect on the current operation or its captured operands.
- a, b, op may change freely after acceptance.
- result updates only after the final RUN edge, when it becomes valid at done.
- result, cb and ovf stay stable from done until the next accepted start.
- Wrap-around: result is modulo 2^WIDTH.
  - Unsigned overflow is reported only via cb.
  - Signed overflow is reported only via ovf.
- Counter width is clog2(WIDTH)+1; no wrap within an operation.

Test Plan:
1. WIDTH=8, op=1, a=0x05, b=0x03, start for 1 cycle
   → busy for 8 cycles, then done pulse exactly 9 edges after start is accepted; result=0x02, cb=0, ovf=0.
2. op=1: a=0x03, b=0x05 → result=0xFE, cb=1, ovf=0. Then a=0x80, b=0x01 → result=0x7F, cb=0, ovf=1.
3. op=0: a=0xFF, b=0x01 → result=0x00, cb=1, ovf=0. Then a=0x7F, b=0x01 → result=0x80, cb=0, ovf=1.
4. Accept start with a=0x10, b=0x01, op=1. At RUN cycle 3, pulse start with a=0x00, b=0x00 and change op to 0.
   → single done; result=0x0F, cb=0; no second operation starts.
5. Assert rst for 1 cycle at RUN cycle 4
   → next cycle busy=0, done=0, result=0, cb=0, ovf=0.
   No done pulse follows; a new start then completes normally.
6. WIDTH=4, exhaustive over all a, b and op (512 ops, back-to-back starts at minimum spacing)
   → result, cb and ovf match the reference model every time; done is seen exactly once per op.
